// File: rtl/apb_uart_tx_pkg.sv
// Shared definitions for the APB UART transmitter.
// Holds the register offsets decoded from paddr[3:0], the serializer state
// encoding, and a helper that maps a latched divisor to its bit period.
package apb_uart_tx_pkg;

    localparam logic [3:0] UART_DATA   = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_DIV    = 4'h8;
    localparam logic [3:0] UART_CTRL   = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A divisor of zero would never complete a bit, so it behaves as one.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        if (div == 16'd0) begin
            return 16'd1;
        end else begin
            return div;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and data (ignored when full)
//   pop, pop_data       read request (ignored when empty); pop_data shows head
//   full, empty, level  occupancy flags and count 0..DEPTH
// DEPTH must be a power of two, at least 2. Pointers carry one extra wrap
// bit so full and empty are distinguishable without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];
    // Fullness is judged on the pre-edge state, so a push into a full FIFO
    // is dropped even when a pop happens in the same cycle.
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Read and write pointers; they wrap naturally through the extra bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, cleared on reset so no stale byte can ever be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/apb_uart_tx.sv
// APB slave UART transmitter: byte FIFO feeding an 8N1 serializer.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   paddr, pdata, psel, penable,
//   pwrite, pstb                    APB request (only paddr[3:0] decoded)
//   prdata, pready, perr            APB response, zero wait states
//   tx                              serial output, idles high, from a flop
//   irq                             level interrupt: enabled, FIFO empty, idle
// Registers: DATA (push), STATUS (full/empty/busy/level), DIV, CTRL.
module apb_uart_tx
    import apb_uart_tx_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    output logic                  tx,
    output logic                  irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // APB decode
    logic          access_s;
    logic [3:0]    offset_s;
    logic          aligned_s;
    logic          wr_s;
    logic          rd_s;
    logic          err_s;
    logic [31:0]   rdata_s;
    logic          unused_s;

    // Registers
    logic [15:0]   div_r;
    logic          irq_en_r;

    // FIFO
    logic          push_s;
    logic          pop_s;
    logic [7:0]    pop_data_s;
    logic          full_s;
    logic          empty_s;
    logic [LW-1:0] level_s;
    logic [3:0]    level4_s;

    // Serializer
    uart_state_e   state_r;
    uart_state_e   next_state_s;
    logic [7:0]    shift_r;
    logic [2:0]    bit_cnt_r;
    logic [15:0]   baud_cnt_r;
    logic [15:0]   div_lat_r;
    logic          bit_done_s;
    logic          last_bit_s;
    logic          busy_s;
    logic          tx_next_s;
    logic          tx_r;

    assign access_s  = psel & penable;
    assign offset_s  = paddr[3:0];
    assign aligned_s = (paddr[1:0] == 2'b00);
    assign wr_s      = access_s & pwrite & aligned_s;
    assign rd_s      = access_s & ~pwrite & aligned_s;
    assign push_s    = wr_s & (offset_s == UART_DATA) & pstb[0] & ~full_s;
    assign pready    = access_s;
    assign perr      = access_s & err_s;
    assign level4_s  = 4'(level_s);
    assign unused_s  = ^{paddr[ADDR_WIDTH-1:4], pdata[DATA_WIDTH-1:16], pstb[3:2]};

    // Slave error classification for the current access.
    always_comb begin
        err_s = 1'b0;
        if (!aligned_s) begin
            err_s = 1'b1;
        end else if (pwrite && (offset_s == UART_STATUS)) begin
            err_s = 1'b1;
        end else if (pwrite && (offset_s == UART_DATA) && (full_s || !pstb[0])) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Read data mux; DATA and unmapped offsets read as zero.
    always_comb begin
        rdata_s = 32'h0;
        case (offset_s)
            UART_STATUS: rdata_s = {24'h0, level4_s, 1'b0, busy_s, empty_s, full_s};
            UART_DIV:    rdata_s = {16'h0, div_r};
            UART_CTRL:   rdata_s = {31'h0, irq_en_r};
            default:     rdata_s = 32'h0;
        endcase
    end

    assign prdata = rd_s ? DATA_WIDTH'(rdata_s) : {DATA_WIDTH{1'b0}};

    // Baud divisor register with per-byte write strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= DEFAULT_DIV;
        end else if (wr_s && (offset_s == UART_DIV)) begin
            if (pstb[0]) begin
                div_r[7:0] <= pdata[7:0];
            end
            if (pstb[1]) begin
                div_r[15:8] <= pdata[15:8];
            end
        end
    end

    // Control register: interrupt enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_r <= 1'b0;
        end else if (wr_s && (offset_s == UART_CTRL) && pstb[0]) begin
            irq_en_r <= pdata[0];
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (pdata[7:0]),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s)
    );

    // The divisor is sampled at pop time, so DIV writes mid-frame only
    // affect the following frame.
    assign bit_done_s = (baud_cnt_r == (bit_period(div_lat_r) - 16'd1));
    assign last_bit_s = (bit_cnt_r == 3'd7);
    assign busy_s     = (state_r != ST_IDLE);
    assign irq        = irq_en_r & empty_s & ~busy_s;
    assign tx         = tx_r;

    // Serializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Serializer next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s && last_bit_s) begin
                    next_state_s = ST_STOP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_done_s && !empty_s) begin
                    next_state_s = ST_START;
                end else if (bit_done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Serializer outputs: FIFO pop and the value tx takes after this edge.
    // tx is computed one cycle ahead so the pin itself comes from a flop.
    always_comb begin
        pop_s     = 1'b0;
        tx_next_s = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    tx_next_s = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    tx_next_s = shift_r[0];
                end else begin
                    tx_next_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_done_s && last_bit_s) begin
                    tx_next_s = 1'b1;
                end else if (bit_done_s) begin
                    tx_next_s = shift_r[1];
                end else begin
                    tx_next_s = shift_r[0];
                end
            end
            ST_STOP: begin
                if (bit_done_s && !empty_s) begin
                    pop_s     = 1'b1;
                    tx_next_s = 1'b0;
                end else begin
                    tx_next_s = 1'b1;
                end
            end
            default: begin
                pop_s     = 1'b0;
                tx_next_s = 1'b1;
            end
        endcase
    end

    // Serializer datapath: byte/divisor latch, bit shifting and baud count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= 16'd0;
            div_lat_r  <= 16'd1;
        end else if (pop_s) begin
            shift_r    <= pop_data_s;
            div_lat_r  <= div_r;
            bit_cnt_r  <= 3'd0;
            baud_cnt_r <= 16'd0;
        end else if (state_r == ST_IDLE) begin
            baud_cnt_r <= 16'd0;
        end else if (bit_done_s) begin
            baud_cnt_r <= 16'd0;
            if (state_r == ST_DATA) begin
                shift_r   <= {1'b0, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
        end
    end

    // Serial output flop; resets high so the line idles during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r <= 1'b1;
        end else begin
            tx_r <= tx_next_s;
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Directed self-checking bench for apb_uart_tx.
// Cycle index k below means "the window after the clock edge k edges past
// the edge that ended the reference DATA write"; tx is sampled on negedges.
module tb_apb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic [31:0] prdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        pready;
    logic        perr;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    apb_uart_tx #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .paddr   (paddr),
        .pdata   (pdata),
        .prdata  (prdata),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pstb    (pstb),
        .pready  (pready),
        .perr    (perr),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Expected line level at position pos (0-based cycle) inside an 8N1 frame.
    function automatic logic exp_tx(input logic [7:0] b, input int pos, input int div);
        int slot;
        slot = pos / div;
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return b[slot-1];
        else return 1'b1;
    endfunction

    // One APB transfer; entered just after a posedge, returns just after the
    // edge that ends the access phase. Response sampled on the access negedge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output logic err, output logic rdy);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = data; pstb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rdata = prdata; err = perr; rdy = pready;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pdata = 32'h0; pstb = 4'h0; paddr = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; logic rdy;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pdata = 32'h0; pstb = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b exp 0", pready); end
        checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", perr); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp 0", prdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp 00000002", rd); end
        checks++; if (rdy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL reset_status_resp got rdy=%b err=%b exp rdy=1 err=0", rdy, err); end
        apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'd868) begin errors++; $display("FAIL reset_div got %0d exp 868", rd); end
        apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", rd); end
        apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL data_read got %h exp 0", rd); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd; logic err; logic rdy; logic e;
        apb_xfer(1'b1, 32'h8, 32'd4, 4'b0011, rd, err, rdy);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL div4_write_perr got %b exp 0", err); end
        apb_xfer(1'b1, 32'h0, 32'h55, 4'b0001, rd, err, rdy);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL data55_write_perr got %b exp 0", err); end
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (k == 0 || k > 40) e = 1'b1;
            else e = exp_tx(8'h55, k - 1, 4);
            checks++; if (tx !== e) begin errors++; $display("FAIL frame55_tx k=%0d got %b exp %b", k, tx, e); end
        end
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL frame55_status_after got %h exp 00000002", rd); end
    endtask

    // Ten writes: the first byte goes straight to the serializer, the next
    // eight fill the FIFO, and the tenth is rejected as full.
    task automatic test_back_to_back();
        logic [31:0] rd; logic err; logic rdy; logic e;
        logic [7:0] bytes [10];
        bytes = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h5A, 8'hC3, 8'h96, 8'hFF};
        apb_xfer(1'b1, 32'h8, 32'd2, 4'b0011, rd, err, rdy);
        for (int i = 0; i < 9; i++) begin
            apb_xfer(1'b1, 32'h0, {24'h0, bytes[i]}, 4'b0001, rd, err, rdy);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_write%0d_perr got %b exp 0", i, err); end
        end
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h85) begin errors++; $display("FAIL b2b_status_full got %h exp 00000085", rd); end
        apb_xfer(1'b1, 32'h0, {24'h0, bytes[9]}, 4'b0001, rd, err, rdy);
        checks++; if (err !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_overflow got perr=%b pready=%b exp 1 1", err, rdy); end
        for (int k = 20; k <= 200; k++) begin
            @(negedge clk);
            if (k <= 180) e = exp_tx(bytes[(k - 1) / 20], (k - 1) % 20, 2);
            else e = 1'b1;
            checks++; if (tx !== e) begin errors++; $display("FAIL b2b_tx k=%0d got %b exp %b", k, tx, e); end
        end
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL b2b_status_after got %h exp 00000002", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic err; logic rdy; logic e;
        apb_xfer(1'b1, 32'hC, 32'h1, 4'b0001, rd, err, rdy);
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle_enabled got %b exp 1", irq); end
        @(posedge clk); #1;
        apb_xfer(1'b1, 32'h8, 32'd1, 4'b0011, rd, err, rdy);
        apb_xfer(1'b1, 32'h0, 32'hA3, 4'b0001, rd, err, rdy);
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            checks++; if (irq !== (k == 11)) begin errors++; $display("FAIL irq_frame k=%0d got %b exp %b", k, irq, (k == 11)); end
            if (k == 0 || k > 10) e = 1'b1;
            else e = exp_tx(8'hA3, k - 1, 1);
            checks++; if (tx !== e) begin errors++; $display("FAIL irq_tx k=%0d got %b exp %b", k, tx, e); end
        end
        @(posedge clk); #1;
        apb_xfer(1'b1, 32'hC, 32'h0, 4'b0001, rd, err, rdy);
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled got %b exp 0", irq); end
        @(posedge clk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; logic rdy;
        apb_xfer(1'b0, 32'h2, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (err !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL err_read_off2 got perr=%b pready=%b exp 1 1", err, rdy); end
        apb_xfer(1'b1, 32'h4, 32'hFF, 4'hF, rd, err, rdy);
        checks++; if (err !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL err_write_status got perr=%b pready=%b exp 1 1", err, rdy); end
        apb_xfer(1'b1, 32'h9, 32'h1234, 4'hF, rd, err, rdy);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misaligned_div got %b exp 1", err); end
        apb_xfer(1'b1, 32'h0, 32'h77, 4'b1110, rd, err, rdy);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_data_nostrobe got %b exp 1", err); end
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_status_unchanged got %h exp 00000002", rd); end
        apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL err_div_unchanged got %h exp 00000001", rd); end
        apb_xfer(1'b1, 32'h8, 32'h0000ABCD, 4'b0010, rd, err, rdy);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL div_hi_write_perr got %b exp 0", err); end
        apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'hAB01) begin errors++; $display("FAIL div_hi_strobe got %h exp 0000ab01", rd); end
    endtask

    task automatic test_div_zero();
        logic [31:0] rd; logic err; logic rdy; logic e;
        apb_xfer(1'b1, 32'h8, 32'h0, 4'b0011, rd, err, rdy);
        apb_xfer(1'b1, 32'h0, 32'h0F, 4'b0001, rd, err, rdy);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k == 0 || k > 10) e = 1'b1;
            else e = exp_tx(8'h0F, k - 1, 1);
            checks++; if (tx !== e) begin errors++; $display("FAIL div0_tx k=%0d got %b exp %b", k, tx, e); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd; logic err; logic rdy; logic e;
        apb_xfer(1'b1, 32'h8, 32'd4, 4'b0011, rd, err, rdy);
        apb_xfer(1'b1, 32'h0, 32'hF3, 4'b0001, rd, err, rdy);
        apb_xfer(1'b1, 32'h0, 32'h11, 4'b0001, rd, err, rdy);
        apb_xfer(1'b1, 32'h0, 32'h22, 4'b0001, rd, err, rdy);
        apb_xfer(1'b1, 32'h0, 32'h33, 4'b0001, rd, err, rdy);
        for (int k = 6; k <= 14; k++) begin
            @(negedge clk);
            e = exp_tx(8'hF3, k - 1, 4);
            checks++; if (tx !== e) begin errors++; $display("FAIL midframe_tx k=%0d got %b exp %b", k, tx, e); end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b exp 1", tx); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx k=%0d got %b exp 1", k, tx); end
        end
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL post_reset_status got %h exp 00000002", rd); end
        apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, err, rdy);
        checks++; if (rd !== 32'd868) begin errors++; $display("FAIL post_reset_div got %0d exp 868", rd); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_irq();
        test_errors();
        test_div_zero();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
